// File: rtl/load_ext_ctrl.sv
// Load-path controller: word read over req/ack, lane select, sign/zero extend.
// Define LOAD_EXT_TIMEOUT_EN to abort a read after TIMEOUT cycles without ack.
module load_ext_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] data
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("load_ext_ctrl: TIMEOUT must be 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_EXT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

`ifdef LOAD_EXT_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  cnt_q, cnt_d;
`endif

    logic        illegal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_val;
    logic        is_lh, is_lhu, is_lb, is_lbu;

    always_comb begin
        illegal = 1'b0;
        if (op_q > OP_LBU) begin
            illegal = 1'b1;
        end else if (op_q == OP_LW && addr_q[1:0] != 2'b00) begin
            illegal = 1'b1;
        end else if ((op_q == OP_LH || op_q == OP_LHU) && addr_q[0]) begin
            illegal = 1'b1;
        end
    end

    // Big-endian lanes: byte 0 of the word sits in rdata[31:24].
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'b00:   byte_sel = rdata_q[31:24];
            2'b01:   byte_sel = rdata_q[23:16];
            2'b10:   byte_sel = rdata_q[15:8];
            default: byte_sel = rdata_q[7:0];
        endcase
        half_sel = addr_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    end

    assign is_lh  = (op_q == OP_LH);
    assign is_lhu = (op_q == OP_LHU);
    assign is_lb  = (op_q == OP_LB);
    assign is_lbu = (op_q == OP_LBU);

    always_comb begin
        ext_val = rdata_q;
        unique case (1'b1)
            is_lh:   ext_val = {{16{half_sel[15]}}, half_sel};
            is_lhu:  ext_val = {16'h0000, half_sel};
            is_lb:   ext_val = {{24{byte_sel[7]}}, byte_sel};
            is_lbu:  ext_val = {24'h000000, byte_sel};
            default: ext_val = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        data_d  = data_q;
        err_d   = 1'b0;
`ifdef LOAD_EXT_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    addr_d  = addr;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef LOAD_EXT_TIMEOUT_EN
                cnt_d = 8'h00;
`endif
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = S_EXT;
`ifdef LOAD_EXT_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'h01;
`endif
                end
            end
            S_EXT: begin
                data_d  = ext_val;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
`ifdef LOAD_EXT_TIMEOUT_EN
            cnt_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef LOAD_EXT_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Decoded from state so reset clears req/busy without a clock edge.
    assign mem_req  = (state_q == S_REQ);
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign data     = data_q;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Randomized bench for load_ext_ctrl against a per-load timeline model.
module tb_load_ext_ctrl;

    localparam int TO = 15;
`ifdef LOAD_EXT_TIMEOUT_EN
    localparam int MAXD = TO - 2;
`else
    localparam int MAXD = 20;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] data;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_data;

    load_ext_ctrl #(.TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .data      (data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] o, input logic [31:0] a);
        if (o > 3'd4) return 1'b0;
        if (o == 3'd0 && a[1:0] != 2'b00) return 1'b0;
        if ((o == 3'd1 || o == 3'd2) && a[0]) return 1'b0;
        return 1'b1;
    endfunction

    // Byte n of the word (n = addr mod 4) is the n-th byte from the top.
    function automatic logic [31:0] ref_load(input logic [2:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] w);
        int          bi;
        logic [7:0]  by;
        logic [15:0] hw;
        bi = int'(a[1:0]);
        by = 8'(w >> (8 * (3 - bi)));
        hw = 16'(w >> (a[1] ? 0 : 16));
        case (o)
            3'd0:    return w;
            3'd1:    return 32'($signed(hw));
            3'd2:    return 32'(hw);
            3'd3:    return 32'($signed(by));
            default: return 32'(by);
        endcase
    endfunction

    // dly < 0: memory never acks.
    task automatic run_load(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] w, input int dly,
                            input bit strays);
        bit ok;
        int ackc;
        int last;
        bit in_req;
        bit stray_ok;
        bit e_busy;
        bit e_done;
        bit e_err;
        ok   = legal(o, a);
        ackc = 2 + dly;
        if (!ok)         last = 2;
        else if (dly < 0) last = 2 + TO;
        else             last = 4 + dly;
        for (int cyc = 0; cyc <= last; cyc++) begin
            @(posedge clock);
            #1;
            in_req = ok && cyc >= 2 &&
                     ((dly < 0) ? (cyc <= 1 + TO) : (cyc <= ackc));
            stray_ok = cyc >= 1 &&
                       (ok ? ((dly < 0) ? (cyc < last) : 1'b1) : (cyc == 1));
            if (cyc == 0) begin
                start = 1'b1;
                op    = o;
                addr  = a;
            end else if (strays && stray_ok && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
                addr  = $urandom();
            end else begin
                start = 1'b0;
            end
            if (ok && dly >= 0 && cyc == ackc) begin
                mem_ack   = 1'b1;
                mem_rdata = w;
            end else if (in_req) begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom();
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom();
            end
            @(negedge clock);
            e_busy = ok ? (cyc >= 1 && ((dly < 0) ? (cyc < last) : 1'b1))
                        : (cyc == 1);
            e_done = ok && dly >= 0 && cyc == last;
            e_err  = (!ok && cyc == 2) || (ok && dly < 0 && cyc == last);
            if (e_done) exp_data = ref_load(o, a, w);
            check("mem_req", 32'(mem_req), 32'(in_req));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("err", 32'(err), 32'(e_err));
            check("data", data, exp_data);
            if (in_req) check("mem_addr", mem_addr, {a[31:2], 2'b00});
        end
        start   = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        reset     = 1'b0;
        start     = 1'b0;
        op        = 3'd0;
        addr      = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        exp_data  = 32'h0;
        #12;
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_data", data, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        run_load(3'd3, 32'h0000_1003, 32'h1234_56F0, 0, 1'b0);
        check("lb_const", data, 32'hFFFF_FFF0);
        run_load(3'd4, 32'h0000_1003, 32'h1234_56F0, 0, 1'b0);
        check("lbu_const", data, 32'h0000_00F0);
        run_load(3'd2, 32'h0000_2000, 32'h8001_7FFF, 0, 1'b0);
        check("lhu_const", data, 32'h0000_8001);
        run_load(3'd1, 32'h0000_2002, 32'h8001_7FFF, 0, 1'b0);
        check("lh_const", data, 32'h0000_7FFF);
        run_load(3'd0, 32'h0000_3002, 32'h5555_5555, 0, 1'b0);
        check("lw_mis_data", data, 32'h0000_7FFF);
        run_load(3'd7, 32'h0000_5000, 32'h5555_5555, 0, 1'b0);
        run_load(3'd0, 32'h0000_4000, 32'hDEAD_BEEF, 5, 1'b1);
        check("lw_const", data, 32'hDEAD_BEEF);

        for (int i = 0; i < 200; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                             : 3'($urandom_range(0, 4));
            ra = $urandom();
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            run_load(ro, ra, $urandom(), int'($urandom_range(0, MAXD)),
                     1'($urandom_range(0, 1)));
        end

`ifdef LOAD_EXT_TIMEOUT_EN
        run_load(3'd0, 32'h0000_6000, 32'h1111_2222, -1, 1'b0);
        check("to_data", data, exp_data);
        run_load(3'd0, 32'h0000_6004, 32'hCAFE_F00D, TO - 1, 1'b0);
        check("to_edge", data, 32'hCAFE_F00D);
`endif

        // Reset while a request is outstanding.
        @(posedge clock);
        #1;
        start = 1'b1;
        op    = 3'd0;
        addr  = 32'h0000_7000;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("pre_rst_req", 32'(mem_req), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_req", 32'(mem_req), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_err", 32'(err), 32'h0);
        check("arst_data", data, 32'h0);
        exp_data = 32'h0;
        @(negedge clock);
        reset = 1'b1;
        run_load(3'd3, 32'h0000_8001, 32'h00A5_0000, 1, 1'b0);
        check("post_rst_lb", data, 32'hFFFF_FFA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/load_ext_ctrl.md
Name: load_ext_ctrl

Overview:
- Multi-cycle controller for the data-memory load path.
- Accepts a load command (LW/LH/LHU/LB/LBU) from the pipeline and issues a word read to data memory through a req/ack handshake.
- Selects the addressed byte or halfword, then sign- or zero-extends it to 32 bits in the same manner as the immediate extender.
- Stalls the pipeline with busy until the result is delivered and flags misaligned accesses.

Parameters:
- TIMEOUT, 15, max cycles waiting for mem_ack before abort (used only with LOAD_EXT_TIMEOUT_EN; range 1..255).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle load command strobe, sampled only in IDLE.
- op  input  3  000=LW, 001=LH, 010=LHU, 011=LB, 100=LBU; others illegal.
- addr  input  32  byte address of load.
- mem_req  output  1  memory read request.
- mem_addr  output  32  word address {addr[31:2],2'b00}.
- mem_ack  input  1  memory read data valid.
- mem_rdata  input  32  memory read word.
- busy  output  1  high from the cycle after start accepted until done cycle inclusive.
- done  output  1  one-cycle result strobe.
- err  output  1  one-cycle error strobe, mutually exclusive with done.
- data  output  32  extended result, held until next done.

Behaviour:
- Reset (reset=0, async): state IDLE; mem_req=0, mem_addr=0, busy=0, done=0, err=0, data=0; latched op/addr cleared.
- States: IDLE, CHECK, REQ, EXT, DONE.
- IDLE: on start=1, latch op and addr, go to CHECK. start in any other state is ignored.
- CHECK (1 cycle): the load is illegal if any of these hold:
  - op>100.
  - LW with addr[1:0]!=00.
  - LH/LHU with addr[0]=1.
- CHECK outcome: illegal -> err=1 for 1 cycle, no memory access, return to IDLE. Legal -> REQ.
- REQ: mem_req=1 and mem_addr stable until mem_ack=1. mem_ack in the same cycle mem_req first rises is accepted. mem_ack while not in REQ is ignored. On ack, capture mem_rdata and go to EXT; mem_req drops the next cycle.
- EXT (1 cycle), big-endian lane select:
  - Byte lanes: addr[1:0]=00 -> rdata[31:24], 01 -> [23:16], 10 -> [15:8], 11 -> [7:0].
  - Halfword lanes: addr[1]=0 -> [31:16], addr[1]=1 -> [15:0].
  - LB/LH: sign-extend using the selected MSB.
  - LBU/LHU: zero-fill.
  - LW: pass-through.
- DONE: register data; done=1 for exactly 1 cycle; return to IDLE. busy falls the following cycle.
- Latency: start at cycle 0, mem_req at cycle 2, ack at cycle k>=2, done at k+2. Zero-wait memory gives done at cycle 4.
- Back-to-back: a new start is accepted in the first IDLE cycle after done.
- data changes only on done; err leaves data unchanged.
- Reset asserted mid-transaction aborts immediately: mem_req drops asynchronously and no done/err is produced.

Optional Feature:
- Macro LOAD_EXT_TIMEOUT_EN.
- Defined: 8-bit wait counter cleared on entry to REQ and incremented each REQ cycle without ack. When the count reaches TIMEOUT with no ack, the controller drops mem_req, pulses err for 1 cycle and returns to IDLE. An ack in the same cycle the limit is reached wins and the load completes normally.
- Undefined: no counter; REQ waits indefinitely.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x123456F0, zero-wait ack -> done at cycle 4, data=0xFFFFFFF0, mem_addr=0x1000.
- LBU, same stimulus -> data=0x000000F0. LHU addr=0x2000, rdata=0x8001_7FFF -> data=0x00008001. LH addr=0x2002 -> data=0x00007FFF.
- LW addr=0x3002 -> err pulse at cycle 2, mem_req never asserted, data unchanged. op=111 with aligned address -> err.
- LW addr=0x4000, ack delayed 5 cycles, rdata=0xDEADBEEF -> mem_req high 6 cycles with stable address, data=0xDEADBEEF, busy high throughout. A start pulse during busy is ignored.
- reset driven low while in REQ -> mem_req/busy go 0 without waiting for a clock edge. After release, a new LB completes normally.
- LOAD_EXT_TIMEOUT_EN with TIMEOUT=15 and no ack -> err after 15 REQ cycles, mem_req low. Ack on the 15th cycle -> done, no err.
